// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer
// Command-driven controller for a WIDTH-bit PIPO register: parallel load plus
// counted shift-left / shift-right / rotate, one shift per clock.
//
// Optional feature macro: SEQ_ROTATE_EN
//   defined   : op 11 rotates left cnt times, err never asserts
//   undefined : op 11 is accepted but does nothing; done and err pulse together
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cmd_valid/ready command handshake (ready only in IDLE)
//   cmd_op          00 LOAD, 01 SHL, 10 SHR, 11 ROT
//   cmd_cnt         shift count (ignored for LOAD)
//   cmd_data        parallel load value (ignored for shifts)
//   ser_in          serial fill bit for SHL/SHR
//   q               register contents
//   ser_out         last bit shifted out
//   busy            not IDLE
//   done            one-cycle completion pulse
//   err             one-cycle pulse with done on an unsupported op
module shift_reg_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e           state, state_d;
  logic [1:0]       op_r, op_d;
  logic [CNT_W-1:0] rem, rem_d;
  logic [WIDTH-1:0] q_d;
  logic             ser_out_d, busy_d, done_d, err_d, ready_d;
  logic             accept_c;
  logic             unsupported_c;

  assign accept_c = cmd_valid & cmd_ready;

  // Ops that are accepted but complete immediately with err
`ifdef SEQ_ROTATE_EN
  assign unsupported_c = 1'b0;
`else
  assign unsupported_c = (cmd_op == OP_ROT);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (cmd_op == OP_LOAD || cmd_cnt == '0 || unsupported_c) state_d = S_DONE;
          else                                                      state_d = S_EXEC;
        end
      end
      S_EXEC:  if (rem == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered datapath and status outputs
  always_comb begin
    q_d       = q;
    ser_out_d = ser_out;
    op_d      = op_r;
    rem_d     = rem;
    err_d     = 1'b0;
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
    ready_d   = (state_d == S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          op_d  = cmd_op;
          rem_d = cmd_cnt;
          err_d = unsupported_c;
          if (cmd_op == OP_LOAD) q_d = cmd_data;
        end
      end
      S_EXEC: begin
        rem_d = rem - CNT_W'(1);
        case (op_r)
          OP_SHL: begin
            q_d       = {q[WIDTH-2:0], ser_in};
            ser_out_d = q[WIDTH-1];
          end
          OP_SHR: begin
            q_d       = {ser_in, q[WIDTH-1:1]};
            ser_out_d = q[0];
          end
`ifdef SEQ_ROTATE_EN
          OP_ROT: begin
            q_d       = {q[WIDTH-2:0], q[WIDTH-1]};
            ser_out_d = q[WIDTH-1];
          end
`endif
          default: begin
            q_d       = q;
            ser_out_d = ser_out;
          end
        endcase
      end
      default: begin
        q_d = q;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      ser_out   <= 1'b0;
      op_r      <= OP_LOAD;
      rem       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      q         <= q_d;
      ser_out   <= ser_out_d;
      op_r      <= op_d;
      rem       <= rem_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      cmd_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed self-checking bench for shift_reg_sequencer (WIDTH=4, CNT_W=3).
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_shift_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       ser_in;
  logic [3:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;
  logic       err;

  int tests = 0;
  int fails = 0;

  shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .ser_in(ser_in), .q(q), .ser_out(ser_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Wait (bounded) for IDLE, present a command for one accept edge, then drop valid.
  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (cmd_ready !== 1'b1) chk("issue_ready_timeout", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Expected register values for SHL cnt=7 from 1111 with ser_in=0
  logic [3:0] shl7_q  [7] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic       shl7_so [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 3'd0; cmd_data = 4'd0; ser_in = 1'b0;
    cyc(); cyc();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy_done_err_so", {28'd0, busy, done, err, ser_out}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // LOAD 1010
    issue(2'b00, 3'd0, 4'b1010);
    chk("load_q", 32'(q), 32'hA);
    chk("load_done", 32'(done), 32'h1);
    chk("load_busy", 32'(busy), 32'h1);
    chk("load_ready_low", 32'(cmd_ready), 32'h0);
    cyc();
    chk("load_done_fall", {30'd0, done, busy}, 32'h0);
    chk("load_ready_back", 32'(cmd_ready), 32'h1);

    // SHL cnt=2 from 0011, ser_in=1
    issue(2'b00, 3'd0, 4'b0011);
    ser_in = 1'b1;
    issue(2'b01, 3'd2, 4'b0000);
    chk("shl_accept_q", 32'(q), 32'h3);
    chk("shl_accept_done", 32'(done), 32'h0);
    cyc();
    chk("shl_q1", 32'(q), 32'h7);
    chk("shl_so1", 32'(ser_out), 32'h0);
    chk("shl_done1", 32'(done), 32'h0);
    cyc();
    chk("shl_q2", 32'(q), 32'hF);
    chk("shl_so2", 32'(ser_out), 32'h0);
    chk("shl_done2", 32'(done), 32'h1);
    cyc();
    chk("shl_done_end", 32'(done), 32'h0);

    // SHR cnt=3 from 1100, ser_in=0
    issue(2'b00, 3'd0, 4'b1100);
    ser_in = 1'b0;
    issue(2'b10, 3'd3, 4'b0000);
    cyc();
    chk("shr_q1", {27'd0, q, ser_out}, {27'd0, 4'b0110, 1'b0});
    cyc();
    chk("shr_q2", {27'd0, q, ser_out}, {27'd0, 4'b0011, 1'b0});
    cyc();
    chk("shr_q3", {27'd0, q, ser_out}, {27'd0, 4'b0001, 1'b1});
    chk("shr_done", 32'(done), 32'h1);

    // LOAD leaves ser_out alone, then SHL cnt=0
    issue(2'b00, 3'd0, 4'b0101);
    chk("load_keeps_so", 32'(ser_out), 32'h1);
    issue(2'b01, 3'd0, 4'b1111);
    chk("cnt0_done", 32'(done), 32'h1);
    chk("cnt0_q", 32'(q), 32'h5);
    cyc();
    chk("cnt0_done_fall", 32'(done), 32'h0);

    // SHL cnt=7 from 1111, cmd_valid held high during EXEC with a LOAD presented
    issue(2'b00, 3'd0, 4'b1111);
    begin
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin cyc(); n++; end
    end
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 3'd7; ser_in = 1'b0;
    cyc();
    cmd_op = 2'b00; cmd_data = 4'b1010; cmd_cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("shl7_q%0d", i + 1), 32'(q), 32'(shl7_q[i]));
      chk($sformatf("shl7_so%0d", i + 1), 32'(ser_out), 32'(shl7_so[i]));
      chk($sformatf("shl7_ready%0d", i + 1), 32'(cmd_ready), 32'h0);
      chk($sformatf("shl7_done%0d", i + 1), 32'(done), (i == 6) ? 32'h1 : 32'h0);
    end
    cmd_valid = 1'b0;
    cyc();
    chk("shl7_no_reaccept_q", 32'(q), 32'h0);
    chk("shl7_ready_back", 32'(cmd_ready), 32'h1);

    // ROT cnt=1 from 1000 (ser_out is 0 going in)
    issue(2'b00, 3'd0, 4'b1000);
    issue(2'b11, 3'd1, 4'b0000);
`ifdef SEQ_ROTATE_EN
    chk("rot_accept_q", 32'(q), 32'h8);
    cyc();
    chk("rot_q", 32'(q), 32'h1);
    chk("rot_so", 32'(ser_out), 32'h1);
    chk("rot_done", 32'(done), 32'h1);
    chk("rot_err", 32'(err), 32'h0);
`else
    chk("rot_q", 32'(q), 32'h8);
    chk("rot_so", 32'(ser_out), 32'h0);
    chk("rot_done_err", {30'd0, done, err}, 32'h3);
    cyc();
    chk("rot_done_err_fall", {30'd0, done, err}, 32'h0);
    chk("rot_q_after", 32'(q), 32'h8);
`endif

    // Reset in the middle of SHR cnt=5 from 0110 with ser_in=1
    issue(2'b00, 3'd0, 4'b0110);
    ser_in = 1'b1;
    issue(2'b10, 3'd5, 4'b0000);
    cyc();
    chk("mid_q1", {27'd0, q, ser_out}, {27'd0, 4'b1011, 1'b0});
    cyc();
    chk("mid_q2", {27'd0, q, ser_out}, {27'd0, 4'b1101, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_flags", {28'd0, busy, done, err, ser_out}, 32'h0);
    cyc(); cyc();
    chk("mid_rst_no_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("mid_ready", 32'(cmd_ready), 32'h1);
    issue(2'b00, 3'd0, 4'b0101);
    chk("mid_load_q", 32'(q), 32'h5);
    chk("mid_load_done", 32'(done), 32'h1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command-driven controller that owns a WIDTH-bit parallel-in/parallel-out register and sequences parallel loads and multi-bit shift operations on it. Upstream logic issues one command at a time over a valid/ready handshake. The block executes one shift per clock and reports completion with a single-cycle pulse. It sits between the PIPO datapath register and whatever control logic needs it loaded, serialised or rotated.

## Interface
- WIDTH, 4, register width in bits (≥2)
- CNT_W, 3, width of the shift-count field
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  2  00 LOAD, 01 SHL, 10 SHR, 11 ROT
- cmd_cnt  in  CNT_W  number of shifts; ignored for LOAD
- cmd_data  in  WIDTH  parallel load value; ignored for shifts
- ser_in  in  1  serial fill bit for SHL/SHR, sampled on every shifting edge
- q  out  WIDTH  register contents, registered
- ser_out  out  1  last bit shifted out, registered
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on an unsupported op

## Operation
- States:
  - IDLE: cmd_ready=1.
  - EXEC: shifting.
  - DONE: done=1 and cmd_ready=0 for exactly one cycle, then IDLE.
- Accept occurs on a rising edge with cmd_valid & cmd_ready. At that edge op, cnt and data are latched. Later changes to cmd_* are ignored until the next accept.
- At the accept edge:
  - LOAD: q<=cmd_data, go to DONE.
  - Shift op with cmd_cnt==0: q unchanged, go to DONE.
  - Otherwise: rem<=cmd_cnt, go to EXEC.
- EXEC, on each edge: perform one shift and decrement rem. If rem==1 before the edge, go to DONE.
  - SHL: q<={q[WIDTH-2:0],ser_in}, ser_out<=q[WIDTH-1].
  - SHR: q<={ser_in,q[WIDTH-1:1]}, ser_out<=q[0].
  - ROT: q<={q[WIDTH-2:0],q[WIDTH-1]}, ser_out<=q[WIDTH-1]. ser_in is ignored.
- ser_out changes only on shifting edges. LOAD leaves ser_out unchanged.
- cmd_cnt is unsigned. The maximum is 2^CNT_W−1, which may exceed WIDTH. Shifting continues normally, with no saturation.
- Reset values: q=0, ser_out=0, busy=0, done=0, err=0, state=IDLE, so cmd_ready=1.
- Reset asserted mid-command aborts it immediately. No done is produced and the command is lost.

## Timing
- Accept at edge k:
  - LOAD: q valid after edge k. done high in cycle k→k+1. cmd_ready high again after edge k+1.
  - N-shift command (N≥1): q updates at edges k+1…k+N. done high in cycle k+N→k+N+1. The next accept is possible at edge k+N+2 at the earliest.
  - cnt==0: same as LOAD timing, no data change.
- Throughput is therefore one command per N+2 cycles for shifts and per 2 cycles for LOAD and cnt==0.
- busy rises after the accept edge and falls after the DONE-cycle edge.
- done and err are registered outputs, never combinational from cmd_*.

## Configuration
- SEQ_ROTATE_EN defined: op 11 executes ROT as described, and err is tied to 0.
- SEQ_ROTATE_EN undefined: op 11 is still accepted, with cnt ignored and q and ser_out unchanged. The state goes straight to DONE, so done and err pulse together in the cycle after the accept.

## Test plan
- Reset then LOAD: assert rst_n low, release, then LOAD cmd_data=4'b1010.
  - Required: q=0 and cmd_ready=1 after reset.
  - Required: q=1010 after the accept edge, done pulses once, busy high for 1 cycle.
- SHL: from q=0011, SHL cnt=2 with ser_in=1.
  - Required: q=0111 then 1111; ser_out=0 then 0.
  - Required: done in the cycle after the second shift.
- SHR: from q=1100, SHR cnt=3 with ser_in=0.
  - Required: q=0110, 0011, 0001; ser_out=0, 0, 1.
- Boundaries:
  - SHL cnt=0: done after 1 cycle, q unchanged.
  - SHL cnt=7 from q=1111 with ser_in=0: q=0000 after 4 shifts, 7 shifting edges total.
  - cmd_valid held high during EXEC: no second accept before IDLE.
- Rotate:
  - With SEQ_ROTATE_EN, ROT cnt=1 from q=1000: q=0001, ser_out=1, err=0.
  - Without SEQ_ROTATE_EN: q stays 1000, done=err=1 for one cycle.
- Reset mid-command: start SHR cnt=5, drop rst_n after 2 shifts.
  - Required: all outputs 0 immediately, no done pulse.
  - Required: after release, cmd_ready=1 and a new LOAD works.
